csr_apb_master: RTL and testbench

CSR_APB_MASTER -- requirements
Module: csr_apb_master

---
 rtl/csr_apb_master_pkg.sv | 23 ++
 rtl/csr_apb_master.sv | 130 +++++++++++++
 tb/tb_csr_apb_master.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/csr_apb_master_pkg.sv
// Shared types and response codes for the CSR-to-APB bridge.
package csr_apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] RSP_OK       = 2'b00;
  localparam logic [1:0] RSP_SLVERR   = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT  = 2'b10;
  localparam logic [1:0] RSP_MISALIGN = 2'b11;

  // Wait counter width: clog2(timeout+1), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/csr_apb_master.sv
// Single-outstanding CSR command port bridged onto an APB requester.
module csr_apb_master
  import csr_apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int unsigned CNT_W  = cnt_width(TIMEOUT);
  localparam bit          TO_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             xfer_done;
  logic             timed_out;

  assign accept    = (state == ST_IDLE) && cmd_valid && cmd_ready;
  // Completion data is only looked at on a genuine APB handshake.
  assign xfer_done = (state == ST_ACCESS) && psel && penable && pready;
  assign timed_out = TO_EN && (state == ST_ACCESS) && !pready && (wait_cnt == TO_VAL);

  // FSM with all outputs registered; reset drops the APB strobes immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= RSP_OK;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            pwrite    <= cmd_write;
            paddr     <= cmd_addr;
            pwdata    <= cmd_wdata;
            pstrb     <= cmd_wstrb;
            if (cmd_addr[1:0] != 2'b00) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= RSP_MISALIGN;
              rsp_rdata <= '0;
            end else begin
              state   <= ST_SETUP;
              psel    <= 1'b1;
              penable <= 1'b0;
            end
          end
        end

        ST_SETUP: begin
          state    <= ST_ACCESS;
          penable  <= 1'b1;
          wait_cnt <= '0;
        end

        ST_ACCESS: begin
          if (xfer_done) begin
            state     <= ST_RESP;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr ? RSP_SLVERR : RSP_OK;
            rsp_rdata <= pwrite ? '0 : prdata;
          end else if (timed_out) begin
            state     <= ST_RESP;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= RSP_TIMEOUT;
            rsp_rdata <= '0;
          end else if (wait_cnt != {CNT_W{1'b1}}) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          psel      <= 1'b0;
          penable   <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_apb_master.sv
// Scoreboarded bench: drives CSR commands, emulates an APB completer, checks responses and timing.
module tb_csr_apb_master;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 4;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic [3:0]        cmd_wstrb = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_err;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [3:0]        pstrb;
  logic [DATA_W-1:0] prdata = '0;
  logic              pready = 1'b0;
  logic              pslverr = 1'b0;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  csr_apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Wait (at negedges) for cmd_ready, bounded; returns cycles waited.
  task automatic wait_ready(output int waited);
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic run_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input int waits, input logic [31:0] rd,
                         input logic se, input bit hang, input int exp_lat,
                         input logic [1:0] exp_err, input logic [31:0] exp_rd,
                         input int hold, input bit keep_valid, input bit exp_now);
    int   waited, cyc, acc;
    bit   aligned, psel_seen, unstable, rsp_moved, ready_seen;
    exp_t e;
    aligned = (addr[1:0] == 2'b00);
    sb.push_back('{rdata: exp_rd, err: exp_err});
    wait_ready(waited);
    if (exp_now) chk("accept_wait", waited, 0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    @(posedge clk);
    cyc = 0; acc = 0; psel_seen = 0; unstable = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) cmd_valid = 1'b0;
      if (psel) psel_seen = 1;
      if (rsp_valid) break;
      if (cyc == 1 && aligned) chk("setup_phase", {psel, penable}, 2'b10);
      if (cyc == 2 && aligned) begin
        chk("acc_phase", {psel, penable, pwrite}, {2'b11, wr});
        chk("acc_paddr", paddr, addr);
        chk("acc_pwdata", pwdata, wd);
        chk("acc_pstrb", pstrb, ws);
      end
      if (psel && penable) begin
        if (paddr !== addr || pwdata !== wd || pstrb !== ws || pwrite !== wr) unstable = 1;
        pready  = !hang && (acc == waits);
        prdata  = pready ? rd : 32'hDEAD_BEEF;
        pslverr = pready ? se : 1'b1;
        acc++;
      end else begin
        pready = 1'b0; prdata = 32'hDEAD_BEEF; pslverr = 1'b1;
      end
    end
    pready = 1'b0; pslverr = 1'b0;
    chk("rsp_latency", cyc, exp_lat);
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_err", rsp_err, e.err);
    end
    chk("resp_apb_idle", {psel, penable}, 2'b00);
    if (aligned) chk("apb_stable", unstable, 0);
    else chk("misalign_psel", psel_seen, 0);
    // Hold the response back and confirm it and cmd_ready do not move.
    rsp_moved = 0; ready_seen = 0;
    for (int h = 0; h < hold; h++) begin
      if (keep_valid) begin cmd_valid = 1'b1; cmd_addr = 16'h0010; end
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== e.rdata || rsp_err !== e.err) rsp_moved = 1;
      if (cmd_ready) ready_seen = 1;
    end
    if (hold > 0) begin
      chk("rsp_hold", rsp_moved, 0);
      chk("ready_hold", ready_seen, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_handshake", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    int waited;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {cmd_ready, rsp_valid, psel, penable, pwrite, rsp_err}, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", cmd_ready, 1);

    //      wr    addr      wdata         strb  wt rdata         se hang lat err    exp_rd       hold keep now
    run_cmd(1'b1, 16'h0004, 32'h0000_0100, 4'hF, 0, 32'h0,        0, 0,   3, 2'b00, 32'h0,        0, 0, 0);
    run_cmd(1'b0, 16'h0008, 32'h0,         4'h0, 3, 32'h0000_00A5, 0, 0,   6, 2'b00, 32'h0000_00A5, 0, 0, 0);
    run_cmd(1'b0, 16'h0100, 32'h0,         4'h0, 1, 32'h0000_1234, 1, 0,   4, 2'b01, 32'h0000_1234, 0, 0, 0);
    run_cmd(1'b0, 16'h0000, 32'h0,         4'h0, 0, 32'h0,        0, 1,   7, 2'b10, 32'h0,        0, 0, 0);
    run_cmd(1'b1, 16'h0102, 32'h5555_AAAA, 4'hF, 0, 32'h0,        0, 0,   1, 2'b11, 32'h0,        0, 0, 0);
    run_cmd(1'b1, 16'h0008, 32'h0BAD_F00D, 4'h3, 0, 32'h0000_0055, 1, 0,   3, 2'b01, 32'h0,        0, 0, 0);
    run_cmd(1'b1, 16'h0000, 32'h1357_9BDF, 4'hC, 2, 32'h0,        0, 0,   5, 2'b00, 32'h0,        5, 1, 0);
    run_cmd(1'b0, 16'h0004, 32'h0,         4'h0, 0, 32'h0000_CAFE, 0, 0,   3, 2'b00, 32'h0000_CAFE, 0, 0, 1);
    run_cmd(1'b0, 16'h0001, 32'h0,         4'h0, 0, 32'h0,        0, 0,   1, 2'b11, 32'h0,        2, 0, 0);

    // Reset pulsed during ACCESS aborts the transfer without a response.
    wait_ready(waited);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0008;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_access", {psel, penable}, 2'b11);
    #2 rst = 1'b0;
    #1 chk("rst_abort", {psel, penable, rsp_valid, cmd_ready}, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort_ready", {cmd_ready, rsp_valid}, 2'b10);

    run_cmd(1'b0, 16'h0100, 32'h0, 4'h0, 1, 32'h8765_4321, 0, 0, 4, 2'b00, 32'h8765_4321, 0, 0, 1);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1);
  end

endmodule
